// File: rtl/posit_quire_accum_raw.sv
// rtl/posit_quire_accum_raw.sv - exact quire accumulator for raw posit terms, normalised back to raw format per frame
module posit_quire_accum_raw #(
  parameter int SCALE_W   = 8,
  parameter int FBITS     = 27,
  parameter int OUT_FBITS = 59,
  parameter int QUIRE_W   = 128,
  parameter int QFRAC     = 64,
  parameter int CNT_W     = 16
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           clr,
  input  logic [SCALE_W+FBITS+2:0]       in_data,
  input  logic                           in_valid,
  input  logic                           in_last,
  output logic                           in_ready,
  output logic [SCALE_W+OUT_FBITS+2:0]   out_data,
  output logic                           out_ovf,
  output logic [CNT_W-1:0]               out_count,
  output logic                           out_valid,
  input  logic                           out_ready
);

  localparam int IN_W = SCALE_W + FBITS + 3;
  localparam int LW   = $clog2(QUIRE_W);
  localparam logic signed [15:0] P_MAX = 16'(QUIRE_W - 2);

  typedef enum logic [1:0] {S_ACC, S_DRAIN, S_NORM, S_HOLD} state_t;

  state_t r_state, w_next;

  logic                 r_drain_cnt;
  logic                 r_s1_valid;
  logic [QUIRE_W-1:0]   r_s1_term;
  logic [QUIRE_W-1:0]   r_quire;
  logic                 r_nar, r_ovf;
  logic [CNT_W-1:0]     r_count;
  logic [QUIRE_W-1:0]   r_abs;
  logic                 r_nsgn, r_nzero, r_nnar;
  logic [LW-1:0]        r_lod;
  logic                 r_out_valid;

  logic                 w_accept, w_handshake;
  logic                 w_sgn, w_inf, w_zero;
  logic [SCALE_W-1:0]   w_scl;
  logic [FBITS-1:0]     w_frac_in;
  logic signed [15:0]   w_p, w_sh;
  logic [QUIRE_W-1:0]   w_mant, w_mag, w_term;
  logic                 w_s1_ovf, w_s1_nar;
  logic [QUIRE_W-1:0]   w_sum, w_abs;
  logic                 w_add_ovf;
  logic [LW-1:0]        w_lod, w_lsh;
  logic [SCALE_W-1:0]   w_scale_out;
  logic [OUT_FBITS-1:0] w_frac_out;

  assign w_accept    = in_valid & in_ready & ~clr;
  assign w_handshake = r_out_valid & out_ready;

  assign w_sgn     = in_data[IN_W-1];
  assign w_scl     = in_data[IN_W-2 -: SCALE_W];
  assign w_frac_in = in_data[FBITS+1:2];
  assign w_inf     = in_data[1];
  assign w_zero    = in_data[0];
  assign w_mant    = {{(QUIRE_W-FBITS-1){1'b0}}, 1'b1, w_frac_in};

  // Align the hidden bit to quire position QFRAC+scale; bits falling below bit 0 are dropped.
  always_comb begin
    w_p      = 16'(QFRAC) + {{(16-SCALE_W){w_scl[SCALE_W-1]}}, w_scl};
    w_sh     = w_p - 16'(FBITS);
    w_mag    = '0;
    w_s1_ovf = 1'b0;
    w_s1_nar = 1'b0;
    if (w_zero)
      w_mag = '0;
    else if (w_inf)
      w_s1_nar = 1'b1;
    else if (w_p > P_MAX)
      w_s1_ovf = 1'b1;
    else if (!w_sh[15])
      w_mag = w_mant << w_sh;
    else
      w_mag = w_mant >> (-w_sh);
    w_term = w_sgn ? -w_mag : w_mag;
  end

  assign w_sum     = r_quire + r_s1_term;
  assign w_add_ovf = (r_quire[QUIRE_W-1] == r_s1_term[QUIRE_W-1]) &&
                     (w_sum[QUIRE_W-1] != r_quire[QUIRE_W-1]);

  // The most-negative quire negates to itself, which reads correctly as unsigned 2^(QUIRE_W-1).
  assign w_abs = r_quire[QUIRE_W-1] ? -r_quire : r_quire;

  always_comb begin
    w_lod = '0;
    for (int i = 0; i < QUIRE_W; i++)
      if (w_abs[i]) w_lod = i[LW-1:0];
  end

  assign w_lsh       = LW'(QUIRE_W - 1) - r_lod;
  assign w_scale_out = SCALE_W'({1'b0, r_lod}) - SCALE_W'(QFRAC);
  assign w_frac_out  = OUT_FBITS'((r_abs << w_lsh) >> (QUIRE_W - 1 - OUT_FBITS));

  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      r_state <= S_ACC;
    else
      r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_ACC:   if (w_accept && in_last) w_next = S_DRAIN;
      S_DRAIN: if (r_drain_cnt) w_next = S_NORM;
      S_NORM:  w_next = S_HOLD;
      S_HOLD:  if (w_handshake) w_next = S_ACC;
      default: w_next = S_ACC;
    endcase
    if (clr) w_next = S_ACC;
  end

  always_comb begin
    in_ready  = (r_state == S_ACC);
    out_valid = r_out_valid;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_drain_cnt <= 1'b0;
      r_s1_valid  <= 1'b0;
      r_s1_term   <= '0;
      r_quire     <= '0;
      r_nar       <= 1'b0;
      r_ovf       <= 1'b0;
      r_count     <= '0;
      r_abs       <= '0;
      r_nsgn      <= 1'b0;
      r_nzero     <= 1'b0;
      r_nnar      <= 1'b0;
      r_lod       <= '0;
      r_out_valid <= 1'b0;
      out_data    <= {{(IN_W-FBITS+OUT_FBITS-1){1'b0}}, 1'b1};
      out_ovf     <= 1'b0;
      out_count   <= '0;
    end else if (clr) begin
      r_drain_cnt <= 1'b0;
      r_s1_valid  <= 1'b0;
      r_quire     <= '0;
      r_nar       <= 1'b0;
      r_ovf       <= 1'b0;
      r_count     <= '0;
      r_out_valid <= 1'b0;
    end else begin
      r_s1_valid <= w_accept;
      r_s1_term  <= w_term;
      if (w_accept) begin
        if (r_count != {CNT_W{1'b1}}) r_count <= r_count + 1'b1;
        r_nar <= r_nar | w_s1_nar;
      end
      r_ovf <= r_ovf | (w_accept & w_s1_ovf) | (r_s1_valid & w_add_ovf);
      if (r_s1_valid) r_quire <= w_sum;
      r_drain_cnt <= (r_state == S_DRAIN) ? ~r_drain_cnt : 1'b0;
      if (r_state == S_NORM) begin
        r_abs   <= w_abs;
        r_nsgn  <= r_quire[QUIRE_W-1];
        r_nzero <= (r_quire == '0);
        r_nnar  <= r_nar;
        r_lod   <= w_lod;
      end
      if (r_state == S_HOLD && !r_out_valid) begin
        r_out_valid <= 1'b1;
        out_ovf     <= r_ovf;
        out_count   <= r_count;
        if (r_nnar)
          out_data <= {1'b0, {SCALE_W{1'b0}}, {OUT_FBITS{1'b0}}, 2'b10};
        else if (r_nzero)
          out_data <= {1'b0, {SCALE_W{1'b0}}, {OUT_FBITS{1'b0}}, 2'b01};
        else
          out_data <= {r_nsgn, w_scale_out, w_frac_out, 2'b00};
      end
      if (r_state == S_HOLD && w_handshake) begin
        r_out_valid <= 1'b0;
        r_quire     <= '0;
        r_nar       <= 1'b0;
        r_ovf       <= 1'b0;
        r_count     <= '0;
      end
    end
  end

endmodule

// File: doc/posit_quire_accum_raw.md
Name: posit_quire_accum_raw

Overview:
- Parametrised exact accumulator for serialized raw posit values `{sgn, scale, fraction, inf, zero}`, as produced by the es2 arithmetic units.
- Terms are summed frame by frame into a wide two's-complement fixed-point quire at one term per cycle, with no feedback hazard and no per-add rounding.
- At frame end the quire is normalised back to raw format with a valid/ready output handshake.
- Sits between the posit multiply stage and the final raw-to-posit encoder in dot-product datapaths.

Parameters:
- SCALE_W, 8, signed scale width for input and output.
- FBITS, 27, input fraction width (hidden bit excluded).
- OUT_FBITS, 59, output fraction width.
- QUIRE_W, 128, quire width, two's complement.
- QFRAC, 64, quire binary point; value = quire × 2^-QFRAC.
- CNT_W, 16, term-counter width.

Ports:
- clk  in  1  clock
- rst  in  1  reset
- clr  in  1  synchronous frame abort
- in_data  in  SCALE_W+FBITS+3  `{sgn, scale, fraction, inf, zero}`, MSB first
- in_valid  in  1  term valid
- in_last  in  1  final term of frame
- in_ready  out  1  block accepts term
- out_data  out  SCALE_W+OUT_FBITS+3  raw result, same field order
- out_ovf  out  1  quire overflow occurred in frame
- out_count  out  CNT_W  terms accepted in frame, saturating
- out_valid  out  1  result valid
- out_ready  in  1  consumer accepts result

Behaviour:
- Reset and clock: rst asynchronous, active-high; clk rising edge.
- Reset values:
  - state = ACC, in_ready = 1, out_valid = 0.
  - quire = 0; nar, ovf and count = 0.
  - out_data = zero encoding (zero = 1, all other fields 0).
  - out_ovf = 0, out_count = 0.
- Accept: a term is accepted when in_valid & in_ready. Every accepted term increments count, saturating at 2^CNT_W − 1.
- Stage S1 (registered), per accepted term:
  - zero = 1: term = 0.
  - inf = 1: term = 0 and nar sticky set.
  - Otherwise form magnitude 1.fraction with the hidden bit at quire position p = QFRAC + scale.
    - p > QUIRE_W − 2: term = 0 and ovf sticky set.
    - Otherwise shift into place; bits below position 0 are truncated (magnitude toward zero).
  - sgn = 1: negate the term (two's complement).
- Stage S2 (registered): quire += term.
  - Signed overflow of the add sets ovf sticky.
  - The quire wraps and is not saturated.
- Sustained rate: one term per cycle with no bubbles.
- FSM:
  - ACC: in_ready = 1. Accepting in_last moves to DRAIN; in_ready drops the following cycle.
  - DRAIN: 2 cycles while S1/S2 flush, then NORM.
  - NORM: 1 cycle. Register |quire|, its sign, and leading-one position L from a leading-one detector, then go to HOLD.
  - HOLD: drive out_valid = 1 with the normalised result.
    - Output fields are held stable until out_valid & out_ready.
    - On handshake: clear quire, nar, ovf and count; go to ACC. in_ready rises the next cycle.
- Latency: last term accepted at edge T gives out_valid = 1 after edge T+4. The next frame's first term can be accepted no earlier than the edge following the output handshake.
- Normalisation:
  - zero = (quire == 0) & ~nar.
  - inf = nar; when inf = 1 all other fields are 0.
  - sgn = quire MSB.
  - scale = L − QFRAC, as a signed SCALE_W value.
  - fraction = the bits of |quire| below L, left-aligned in OUT_FBITS, truncated or zero-padded.
  - The most-negative quire is treated as magnitude 2^(QUIRE_W−1).
- out_ovf and out_count reflect the frame and are valid alongside out_data.
- A frame consisting of a single term with in_last behaves normally.
- in_valid while in_ready = 0 is ignored; the source holds the term.
- clr:
  - Any state: next cycle state = ACC, quire, flags and count = 0, S1 invalidated, out_valid = 0.
  - Any term presented together with clr is discarded.
  - clr wins over in_last and over the out handshake.
- rst mid-frame: all state returns to reset values immediately; any partial sum is lost.

Test Plan:
- Sum 1.0 (s0, sc0, f0), 1.5 (f MSB = 1), −0.5 (s1, sc −1, f0), last on third -> after 4 cycles out_valid, out = s0, scale 1, fraction 0, zero 0, count 3.
- Exactness: 2^20, 2^-20, −2^20 -> out scale −20, fraction 0, sgn 0, ovf 0.
- Cancellation: 3.0 then −3.0 last -> out zero = 1, sgn 0, scale 0, count 2.
- NaR and overflow: term with inf = 1 mid-frame -> out inf = 1, other fields 0. Separate frame with scale 70 -> out_ovf = 1.
- Backpressure: hold out_ready = 0 for 10 cycles -> out_data stable, in_ready = 0. Release -> handshake, in_ready = 1 next cycle. Next frame sum 2.0 + 2.0 -> scale 2, fraction 0.
- clr at cycle 3 of a 5-term frame -> no out_valid. A new frame 1.0 (last) -> out 1.0, count 1.
